// File: rtl/add_sub_accumulator.sv
// Command sequencer and running two's-complement accumulator wrapped around an
// external combinational adder/subtracter attached through the add_* ports.
module add_sub_accumulator #(
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_opcode,
    input  logic [DATA_W-1:0] add_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_neg,
    output logic              res_ovf,
    output logic              ovf_sticky,
    output logic [DATA_W-1:0] acc
);

    localparam logic [DATA_W-1:0] ZERO    = '0;
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    state_t            state, state_d;
    op_t               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] add_b_d;
    logic              add_opcode_d;
    logic              cmd_ready_d;
    logic              res_valid_d;
    logic [DATA_W-1:0] res_data_d;
    logic              res_zero_d;
    logic              res_neg_d;
    logic              res_ovf_d;
    logic              ovf_sticky_d;

    logic              a_msb, b_msb, s_msb;
    logic              exec_ovf;
    logic [DATA_W-1:0] exec_value;

    // The adder always sees the live accumulator on operand a.
    assign add_a = acc;

    assign a_msb = acc[DATA_W-1];
    assign b_msb = data_q[DATA_W-1];
    assign s_msb = add_sum[DATA_W-1];

    // Result of the command held in op_q/data_q, including overflow clamping.
    always_comb begin
        exec_ovf   = 1'b0;
        exec_value = ZERO;
        case (op_q)
            OP_LOAD: begin
                exec_value = data_q;
            end
            OP_ADD: begin
                exec_value = add_sum;
                exec_ovf   = (a_msb == b_msb) && (s_msb != a_msb);
            end
            OP_SUB: begin
                exec_value = add_sum;
                exec_ovf   = (a_msb != b_msb) && (s_msb != a_msb);
            end
            OP_CLEAR: begin
                exec_value = ZERO;
            end
            default: begin
                exec_value = ZERO;
            end
        endcase
        if (exec_ovf && SATURATE) begin
            exec_value = a_msb ? MIN_NEG : MAX_POS;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d      = state;
        op_d         = op_q;
        data_d       = data_q;
        acc_d        = acc;
        add_b_d      = add_b;
        add_opcode_d = add_opcode;
        cmd_ready_d  = cmd_ready;
        res_valid_d  = res_valid;
        res_data_d   = res_data;
        res_zero_d   = res_zero;
        res_neg_d    = res_neg;
        res_ovf_d    = res_ovf;
        ovf_sticky_d = ovf_sticky;

        case (state)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    op_d         = op_t'(cmd_op);
                    data_d       = cmd_data;
                    add_b_d      = cmd_data;
                    add_opcode_d = (op_t'(cmd_op) == OP_SUB);
                    cmd_ready_d  = 1'b0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                acc_d        = exec_value;
                res_data_d   = exec_value;
                res_zero_d   = (exec_value == ZERO);
                res_neg_d    = exec_value[DATA_W-1];
                res_ovf_d    = exec_ovf;
                ovf_sticky_d = (op_q == OP_CLEAR) ? 1'b0 : (ovf_sticky | exec_ovf);
                res_valid_d  = 1'b1;
                add_b_d      = ZERO;
                add_opcode_d = 1'b0;
                cmd_ready_d  = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                cmd_ready_d = 1'b0;
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers; reset discards any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_LOAD;
            data_q     <= ZERO;
            acc        <= ZERO;
            add_b      <= ZERO;
            add_opcode <= 1'b0;
            cmd_ready  <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= ZERO;
            res_zero   <= 1'b1;
            res_neg    <= 1'b0;
            res_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            op_q       <= op_d;
            data_q     <= data_d;
            acc        <= acc_d;
            add_b      <= add_b_d;
            add_opcode <= add_opcode_d;
            cmd_ready  <= cmd_ready_d;
            res_valid  <= res_valid_d;
            res_data   <= res_data_d;
            res_zero   <= res_zero_d;
            res_neg    <= res_neg_d;
            res_ovf    <= res_ovf_d;
            ovf_sticky <= ovf_sticky_d;
        end
    end

endmodule
